// File: rtl/sc_host_if.sv
// Avalon-MM host front end for the sector controller: control/type registers, write forwarding,
// IFT-completion detection and interrupt. Optional watchdog enabled by defining SC_WATCHDOG_EN.
module sc_host_if #(
    parameter int          STATUS_BITS    = 6,
    parameter int          DONE_HOLD      = 4,
    parameter logic [3:0]  WAIT_CODE      = 4'h7,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [1:0]  AVL_address_i,
    input  logic        AVL_write_i,
    input  logic        AVL_read_i,
    input  logic [31:0] AVL_writedata_i,
    output logic [31:0] AVL_readdata_o,
    output logic        AVL_irq_o,
    output logic        SC_type_reg_o,
    output logic [3:0]  SC_cmd_reg_o,
    output logic        SC_avl_write_o,
    output logic        SC_avl_address_o,
    output logic [31:0] SC_avl_writedata_o,
    input  logic [31:0] SC_avl_readdata_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int               HW       = $clog2(DONE_HOLD + 1);
    localparam logic [HW-1:0]    HOLD_TGT = HW'(DONE_HOLD);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          type_q, type_d;
    logic          done_q, done_d;
    logic          reject_q, reject_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          sc_wr_q, sc_wr_d;
    logic [31:0]   sc_wdata_q, sc_wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          timeout_q, timeout_d;

    logic busy, cond, abort, wr0, wr1, wr2, wr3;
    logic [3:0]             sc_state;
    logic [STATUS_BITS-1:0] sc_count;

    assign sc_state = SC_avl_readdata_i[3:0];
    assign sc_count = SC_avl_readdata_i[STATUS_BITS+3:4];
    assign cond     = (sc_state == WAIT_CODE) && (sc_count == '0);
    assign busy     = (state_q == RUN) || (state_q == SETTLE);
    assign wr0      = AVL_write_i && (AVL_address_i == 2'd0);
    assign wr1      = AVL_write_i && (AVL_address_i == 2'd1);
    assign wr2      = AVL_write_i && (AVL_address_i == 2'd2);
    assign wr3      = AVL_write_i && (AVL_address_i == 2'd3);
    assign abort    = wr1 && busy && !AVL_writedata_i[0];

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        type_d     = type_q;
        done_d     = done_q;
        reject_d   = reject_q;
        irq_en_d   = irq_en_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        sc_wr_d    = 1'b0;
        sc_wdata_d = sc_wdata_q;
        rdata_d    = rdata_q;
        irq_d      = irq_en_q & (done_q | timeout_q);

        if (busy && cnt_q != 32'hFFFF_FFFF)
            cnt_d = cnt_q + 32'd1;

        // Clears are applied first so any same-cycle set overrides them
        if (wr2) begin
            if (AVL_writedata_i[3]) reject_d  = 1'b0;
            if (AVL_writedata_i[2]) timeout_d = 1'b0;
            if (AVL_writedata_i[1]) done_d    = 1'b0;
        end
        if (wr3)
            irq_en_d = AVL_writedata_i[0];
        if (wr0) begin
            if (busy) begin
                reject_d = 1'b1;
            end else begin
                sc_wr_d    = 1'b1;
                sc_wdata_d = AVL_writedata_i;
            end
        end
        if (wr1) begin
            if (!busy) begin
                cmd_d  = AVL_writedata_i[3:0];
                type_d = AVL_writedata_i[4];
                if (AVL_writedata_i[0]) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    hold_d  = '0;
                end
            end else if (abort) begin
                cmd_d   = {AVL_writedata_i[3:1], 1'b0};
                type_d  = AVL_writedata_i[4];
                state_d = IDLE;
                hold_d  = '0;
            end else begin
                reject_d = 1'b1;
            end
        end

        if (!abort) begin
            case (state_q)
                RUN: if (cond) begin
                    state_d = SETTLE;
                    hold_d  = HW'(1);
                end
                SETTLE: if (!cond) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else if (hold_q + HW'(1) == HOLD_TGT) begin
                    state_d  = DONE;
                    cmd_d[0] = 1'b0;
                    done_d   = 1'b1;
                    hold_d   = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
                DONE: if (wr2 && AVL_writedata_i[1]) state_d = IDLE;
                default: ;
            endcase
        end

`ifdef SC_WATCHDOG_EN
        if (!abort && busy && state_d != DONE && cnt_q == TIMEOUT_CYCLES) begin
            state_d   = IDLE;
            cmd_d[0]  = 1'b0;
            timeout_d = 1'b1;
            hold_d    = '0;
        end
`endif

        if (AVL_read_i) begin
            case (AVL_address_i)
                2'd0:    rdata_d = SC_avl_readdata_i;
                2'd1:    rdata_d = {27'b0, type_q, cmd_q};
                2'd2:    rdata_d = {28'b0, reject_q, timeout_q, done_q, busy};
                default: rdata_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            type_q     <= 1'b0;
            done_q     <= 1'b0;
            reject_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            hold_q     <= '0;
            cnt_q      <= '0;
            sc_wr_q    <= 1'b0;
            sc_wdata_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            type_q     <= type_d;
            done_q     <= done_d;
            reject_q   <= reject_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            sc_wr_q    <= sc_wr_d;
            sc_wdata_q <= sc_wdata_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef SC_WATCHDOG_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) timeout_q <= 1'b0;
        else         timeout_q <= timeout_d;
    end
`else
    logic unused_timeout;
    assign timeout_q      = 1'b0;
    assign unused_timeout = ^{timeout_d, TIMEOUT_CYCLES};
`endif

    assign AVL_readdata_o     = rdata_q;
    assign AVL_irq_o          = irq_q;
    assign SC_type_reg_o      = type_q;
    assign SC_cmd_reg_o       = cmd_q;
    assign SC_avl_write_o     = sc_wr_q;
    assign SC_avl_address_o   = 1'b0;
    assign SC_avl_writedata_o = sc_wdata_q;

endmodule
